// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage: ALU op classes,
// funct codes, ALU select, multiplier FSM states and forwarding selects.
package ex_pkg;

   localparam logic [1:0] ADDOP = 2'b00;
   localparam logic [1:0] SUBOP = 2'b01;
   localparam logic [1:0] RTYPE = 2'b10;

   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_MULT = 6'h18;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_MUL
   } alu_sel_e;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } mul_state_e;

   function automatic alu_sel_e funct_decode(
      input logic [5:0] funct
   );
      alu_sel_e sel;
      sel = ALU_ADD;
      unique case (1'b1)
         (funct == F_SUB):  sel = ALU_SUB;
         (funct == F_AND):  sel = ALU_AND;
         (funct == F_OR):   sel = ALU_OR;
         (funct == F_SLT):  sel = ALU_SLT;
         (funct == F_MULT): sel = ALU_MUL;
         default:           sel = ALU_ADD;
      endcase
      return sel;
   endfunction

   function automatic alu_sel_e alu_decode(
      input logic [1:0] aluop,
      input logic [5:0] funct
   );
      alu_sel_e sel;
      sel = ALU_ADD;
      unique case (1'b1)
         (aluop == SUBOP): sel = ALU_SUB;
         (aluop == RTYPE): sel = funct_decode(funct);
         default:          sel = ALU_ADD;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ex_stage_seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports: clk, reset (async, active low), start, abort, a, b -> busy, done, product.
module seq_mult
   import ex_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   mul_state_e        state;
   mul_state_e        state_n;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_n;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_n;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mcand_n;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] mplier_n;
   logic [DATA_W-1:0] sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         acc    <= acc_n;
         mcand  <= mcand_n;
         mplier <= mplier_n;
      end
   end

   // Partial sum including the bit processed this cycle; on the last
   // cycle this is the finished product, consumed on the same edge.
   assign sum     = acc + (mplier[0] ? mcand : '0);
   assign product = sum;
   assign busy    = (state == S_MUL);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      acc_n    = acc;
      mcand_n  = mcand;
      mplier_n = mplier;
      done     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_n  = S_MUL;
               cnt_n    = '0;
               acc_n    = '0;
               mcand_n  = a;
               mplier_n = b;
            end
         end
         S_MUL: begin
            if (abort) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               acc_n    = sum;
               mcand_n  = mcand << 1;
               mplier_n = mplier >> 1;
               cnt_n    = cnt + 1'b1;
               if (cnt == LAST) begin
                  done    = 1'b1;
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM register: ALU, branch target, dest select, MULT.
// Ports: ID/EX control+operands in; busy and ex_mem_* bundle out.
// Optional EX_FORWARD_EN adds fwd_a_sel/fwd_b_sel/mem_fwd_data/wb_fwd_data.
module ex_stage
   import ex_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              flush,
   input  logic [1:0]        ctl_wb,
   input  logic              ctl_branch,
   input  logic              ctl_memread,
   input  logic              ctl_memwrite,
   input  logic              ctl_regdst,
   input  logic              ctl_alusrc,
   input  logic [1:0]        ctl_aluop,
   input  logic [DATA_W-1:0] npc,
   input  logic [DATA_W-1:0] rdata1,
   input  logic [DATA_W-1:0] rdata2,
   input  logic [DATA_W-1:0] imm,
   input  logic [REG_W-1:0]  rt,
   input  logic [REG_W-1:0]  rd,
`ifdef EX_FORWARD_EN
   input  logic [1:0]        fwd_a_sel,
   input  logic [1:0]        fwd_b_sel,
   input  logic [DATA_W-1:0] mem_fwd_data,
   input  logic [DATA_W-1:0] wb_fwd_data,
`endif
   output logic              busy,
   output logic              ex_mem_valid,
   output logic [1:0]        ex_mem_ctl_wb,
   output logic              ex_mem_branch,
   output logic              ex_mem_memread,
   output logic              ex_mem_memwrite,
   output logic              ex_mem_zero,
   output logic [DATA_W-1:0] ex_mem_target,
   output logic [DATA_W-1:0] ex_mem_alu_result,
   output logic [DATA_W-1:0] ex_mem_write_data,
   output logic [REG_W-1:0]  ex_mem_write_reg
);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_fb;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] target;
   logic [DATA_W-1:0] prod;
   logic [REG_W-1:0]  write_reg;
   alu_sel_e          alu_sel;
   logic              is_mult;
   logic              mul_start;
   logic              mul_done;
   logic              zero;

   logic [1:0]        c_wb;
   logic              c_branch;
   logic              c_memread;
   logic              c_memwrite;
   logic [REG_W-1:0]  c_wreg;

`ifdef EX_FORWARD_EN
   always_comb begin
      op_a = rdata1;
      case (fwd_a_sel)
         FWD_MEM: op_a = mem_fwd_data;
         FWD_WB:  op_a = wb_fwd_data;
         default: op_a = rdata1;
      endcase
   end

   always_comb begin
      op_fb = rdata2;
      case (fwd_b_sel)
         FWD_MEM: op_fb = mem_fwd_data;
         FWD_WB:  op_fb = wb_fwd_data;
         default: op_fb = rdata2;
      endcase
   end
`else
   assign op_a  = rdata1;
   assign op_fb = rdata2;
`endif

   assign op_b      = ctl_alusrc ? imm : op_fb;
   assign write_reg = ctl_regdst ? rd : rt;
   assign target    = npc + (imm << 2);
   assign alu_sel   = alu_decode(ctl_aluop, imm[5:0]);
   assign is_mult   = (alu_sel == ALU_MUL);

   always_comb begin
      alu_result = '0;
      unique case (alu_sel)
         ALU_ADD: alu_result = op_a + op_b;
         ALU_SUB: alu_result = op_a - op_b;
         ALU_AND: alu_result = op_a & op_b;
         ALU_OR:  alu_result = op_a | op_b;
         ALU_SLT: alu_result = {{(DATA_W-1){1'b0}},
                                ($signed(op_a) < $signed(op_b))};
         default: alu_result = '0;
      endcase
   end

   assign zero = (alu_result == '0);

   // A squashed MULT must not start, or it would later write back.
   assign mul_start = in_valid & is_mult & ~flush;

   seq_mult #(
      .DATA_W (DATA_W)
   ) u_mult (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .abort   (flush),
      .a       (op_a),
      .b       (op_b),
      .busy    (busy),
      .done    (mul_done),
      .product (prod)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c_wb       <= '0;
         c_branch   <= 1'b0;
         c_memread  <= 1'b0;
         c_memwrite <= 1'b0;
         c_wreg     <= '0;
      end else if (mul_start && !busy) begin
         c_wb       <= ctl_wb;
         c_branch   <= ctl_branch;
         c_memread  <= ctl_memread;
         c_memwrite <= ctl_memwrite;
         c_wreg     <= write_reg;
      end
   end

   // Default is a bubble; flush wins over both completion paths.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_mem_valid      <= 1'b0;
         ex_mem_ctl_wb     <= '0;
         ex_mem_branch     <= 1'b0;
         ex_mem_memread    <= 1'b0;
         ex_mem_memwrite   <= 1'b0;
         ex_mem_zero       <= 1'b0;
         ex_mem_target     <= '0;
         ex_mem_alu_result <= '0;
         ex_mem_write_data <= '0;
         ex_mem_write_reg  <= '0;
      end else begin
         ex_mem_valid      <= 1'b0;
         ex_mem_ctl_wb     <= '0;
         ex_mem_branch     <= 1'b0;
         ex_mem_memread    <= 1'b0;
         ex_mem_memwrite   <= 1'b0;
         ex_mem_zero       <= 1'b0;
         ex_mem_target     <= '0;
         ex_mem_alu_result <= '0;
         ex_mem_write_data <= '0;
         ex_mem_write_reg  <= '0;
         if (!flush) begin
            if (mul_done) begin
               ex_mem_valid      <= 1'b1;
               ex_mem_ctl_wb     <= c_wb;
               ex_mem_branch     <= c_branch;
               ex_mem_memread    <= c_memread;
               ex_mem_memwrite   <= c_memwrite;
               ex_mem_zero       <= (prod == '0);
               ex_mem_alu_result <= prod;
               ex_mem_write_reg  <= c_wreg;
            end else if (!busy && in_valid && !is_mult) begin
               ex_mem_valid      <= 1'b1;
               ex_mem_ctl_wb     <= ctl_wb;
               ex_mem_branch     <= ctl_branch;
               ex_mem_memread    <= ctl_memread;
               ex_mem_memwrite   <= ctl_memwrite;
               ex_mem_zero       <= zero;
               ex_mem_target     <= target;
               ex_mem_alu_result <= alu_result;
               ex_mem_write_data <= op_fb;
               ex_mem_write_reg  <= write_reg;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: cycle model plus directed vectors.
// Covers reset, ALU ops, branch/flush, load/store, MULT and its abort.
module tb_ex_stage;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          flush = 1'b0;
   logic [1:0]    ctl_wb = '0;
   logic          ctl_branch = 1'b0;
   logic          ctl_memread = 1'b0;
   logic          ctl_memwrite = 1'b0;
   logic          ctl_regdst = 1'b0;
   logic          ctl_alusrc = 1'b0;
   logic [1:0]    ctl_aluop = '0;
   logic [W-1:0]  npc = '0;
   logic [W-1:0]  rdata1 = '0;
   logic [W-1:0]  rdata2 = '0;
   logic [W-1:0]  imm = '0;
   logic [4:0]    rt = '0;
   logic [4:0]    rd = '0;
`ifdef EX_FORWARD_EN
   logic [1:0]    fwd_a_sel = '0;
   logic [1:0]    fwd_b_sel = '0;
   logic [W-1:0]  mem_fwd_data = '0;
   logic [W-1:0]  wb_fwd_data = '0;
`endif

   logic          busy;
   logic          ex_mem_valid;
   logic [1:0]    ex_mem_ctl_wb;
   logic          ex_mem_branch;
   logic          ex_mem_memread;
   logic          ex_mem_memwrite;
   logic          ex_mem_zero;
   logic [W-1:0]  ex_mem_target;
   logic [W-1:0]  ex_mem_alu_result;
   logic [W-1:0]  ex_mem_write_data;
   logic [4:0]    ex_mem_write_reg;

   ex_stage #(.DATA_W(W), .REG_W(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .flush             (flush),
      .ctl_wb            (ctl_wb),
      .ctl_branch        (ctl_branch),
      .ctl_memread       (ctl_memread),
      .ctl_memwrite      (ctl_memwrite),
      .ctl_regdst        (ctl_regdst),
      .ctl_alusrc        (ctl_alusrc),
      .ctl_aluop         (ctl_aluop),
      .npc               (npc),
      .rdata1            (rdata1),
      .rdata2            (rdata2),
      .imm               (imm),
      .rt                (rt),
      .rd                (rd),
`ifdef EX_FORWARD_EN
      .fwd_a_sel         (fwd_a_sel),
      .fwd_b_sel         (fwd_b_sel),
      .mem_fwd_data      (mem_fwd_data),
      .wb_fwd_data       (wb_fwd_data),
`endif
      .busy              (busy),
      .ex_mem_valid      (ex_mem_valid),
      .ex_mem_ctl_wb     (ex_mem_ctl_wb),
      .ex_mem_branch     (ex_mem_branch),
      .ex_mem_memread    (ex_mem_memread),
      .ex_mem_memwrite   (ex_mem_memwrite),
      .ex_mem_zero       (ex_mem_zero),
      .ex_mem_target     (ex_mem_target),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_write_data (ex_mem_write_data),
      .ex_mem_write_reg  (ex_mem_write_reg)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_a, m_fb, m_b, m_alu, m_tgt;
   logic [4:0]   m_wreg;
   logic         m_mult;

   always_comb begin
      m_a  = rdata1;
      m_fb = rdata2;
`ifdef EX_FORWARD_EN
      if (fwd_a_sel == 2'b10) m_a = mem_fwd_data;
      if (fwd_a_sel == 2'b01) m_a = wb_fwd_data;
      if (fwd_b_sel == 2'b10) m_fb = mem_fwd_data;
      if (fwd_b_sel == 2'b01) m_fb = wb_fwd_data;
`endif
      m_b    = ctl_alusrc ? imm : m_fb;
      m_wreg = ctl_regdst ? rd : rt;
      m_tgt  = npc + imm * 4;
      m_mult = (ctl_aluop == 2'b10) && (imm[5:0] == 6'h18);
      m_alu  = m_a + m_b;
      if (ctl_aluop == 2'b01) m_alu = m_a - m_b;
      if (ctl_aluop == 2'b10) begin
         case (imm[5:0])
            6'h22: m_alu = m_a - m_b;
            6'h24: m_alu = m_a & m_b;
            6'h25: m_alu = m_a | m_b;
            6'h2A: m_alu = ($signed(m_a) < $signed(m_b)) ? 1 : 0;
            default: m_alu = m_a + m_b;
         endcase
      end
   end

   logic         mb_busy = 1'b0;
   int           mb_left = 0;
   logic [W-1:0] mb_prod = '0;
   logic [1:0]   mb_wb = '0;
   logic         mb_br = 1'b0, mb_mr = 1'b0, mb_mw = 1'b0;
   logic [4:0]   mb_wreg = '0;

   logic         e_valid = 1'b0, e_br = 1'b0, e_mr = 1'b0;
   logic         e_mw = 1'b0, e_zero = 1'b0, e_full = 1'b1;
   logic [1:0]   e_wb = '0;
   logic [W-1:0] e_alu = '0, e_tgt = '0, e_wd = '0;
   logic [4:0]   e_wreg = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mb_busy <= 1'b0;
         mb_left <= 0;
         e_valid <= 1'b0; e_wb <= '0; e_br <= 1'b0; e_mr <= 1'b0;
         e_mw <= 1'b0; e_zero <= 1'b0; e_alu <= '0; e_tgt <= '0;
         e_wd <= '0; e_wreg <= '0; e_full <= 1'b1;
      end else begin
         e_valid <= 1'b0; e_wb <= '0; e_br <= 1'b0; e_mr <= 1'b0;
         e_mw <= 1'b0; e_zero <= 1'b0; e_alu <= '0; e_tgt <= '0;
         e_wd <= '0; e_wreg <= '0; e_full <= 1'b1;
         if (flush) begin
            mb_busy <= 1'b0;
         end else if (mb_busy) begin
            mb_left <= mb_left - 1;
            if (mb_left == 1) begin
               mb_busy <= 1'b0;
               e_valid <= 1'b1; e_wb <= mb_wb; e_br <= mb_br;
               e_mr <= mb_mr; e_mw <= mb_mw; e_alu <= mb_prod;
               e_zero <= (mb_prod == 0); e_wreg <= mb_wreg;
               e_full <= 1'b0;
            end
         end else if (in_valid && m_mult) begin
            mb_busy <= 1'b1;
            mb_left <= W;
            mb_prod <= m_a * m_b;
            mb_wb <= ctl_wb; mb_br <= ctl_branch; mb_mr <= ctl_memread;
            mb_mw <= ctl_memwrite; mb_wreg <= m_wreg;
         end else if (in_valid) begin
            e_valid <= 1'b1; e_wb <= ctl_wb; e_br <= ctl_branch;
            e_mr <= ctl_memread; e_mw <= ctl_memwrite;
            e_alu <= m_alu; e_zero <= (m_alu == 0);
            e_tgt <= m_tgt; e_wd <= m_fb; e_wreg <= m_wreg;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_valid", 32'(ex_mem_valid), 32'(e_valid));
      chk("m_wb", 32'(ex_mem_ctl_wb), 32'(e_wb));
      chk("m_branch", 32'(ex_mem_branch), 32'(e_br));
      chk("m_memread", 32'(ex_mem_memread), 32'(e_mr));
      chk("m_memwrite", 32'(ex_mem_memwrite), 32'(e_mw));
      chk("m_zero", 32'(ex_mem_zero), 32'(e_zero));
      chk("m_alu", ex_mem_alu_result, e_alu);
      chk("m_wreg", 32'(ex_mem_write_reg), 32'(e_wreg));
      chk("m_busy", 32'(busy), 32'(mb_busy));
      if (e_full) begin
         chk("m_target", ex_mem_target, e_tgt);
         chk("m_wdata", ex_mem_write_data, e_wd);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      in_valid = 1'b0; flush = 1'b0; ctl_wb = '0; ctl_branch = 1'b0;
      ctl_memread = 1'b0; ctl_memwrite = 1'b0; ctl_regdst = 1'b0;
      ctl_alusrc = 1'b0; ctl_aluop = '0; npc = '0; rdata1 = '0;
      rdata2 = '0; imm = '0; rt = '0; rd = '0;
`ifdef EX_FORWARD_EN
      fwd_a_sel = '0; fwd_b_sel = '0;
      mem_fwd_data = '0; wb_fwd_data = '0;
`endif
   endtask

   task automatic set_op(input logic [1:0] op, input logic src,
                         input logic dst, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] im);
      clr();
      in_valid = 1'b1; ctl_aluop = op; ctl_alusrc = src;
      ctl_regdst = dst; rdata1 = a; rdata2 = b; imm = im;
   endtask

   task automatic run_mult(input string nm, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] expv);
      int n;
      int bub;
      set_op(2'b10, 1'b0, 1'b1, a, b, 32'h18);
      rd = 5'd9; rt = 5'd2; ctl_wb = 2'b10;
      tick();
      n = 0;
      bub = 0;
      while (busy && n < 40) begin
         if (ex_mem_valid) bub++;
         n++;
         tick();
      end
      clr();
      chk({nm, "_busy_cycles"}, 32'(n), 32);
      chk({nm, "_bubbles"}, 32'(bub), 0);
      chk({nm, "_valid"}, 32'(ex_mem_valid), 1);
      chk({nm, "_product"}, ex_mem_alu_result, expv);
      chk({nm, "_wreg"}, 32'(ex_mem_write_reg), 9);
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] im;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int cnt;
      vecs = '{
         '{2'b10, 32'h24, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000},
         '{2'b10, 32'h25, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0},
         '{2'b10, 32'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
         '{2'b10, 32'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000},
         '{2'b10, 32'h20, 32'h00000007, 32'h00000008, 32'h0000000F},
         '{2'b10, 32'h00, 32'h00000007, 32'h00000008, 32'h0000000F},
         '{2'b11, 32'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
         '{2'b01, 32'h00, 32'h00000003, 32'h00000005, 32'hFFFFFFFE}
      };
      clr();
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(ex_mem_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b1;

      // live result, then asynchronous reset clears it at once
      set_op(2'b00, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0);
      rd = 5'd5;
      tick();
      chk("pre_rst_alu", ex_mem_alu_result, 3);
      reset = 1'b0;
      #1;
      chk("async_rst_valid", 32'(ex_mem_valid), 0);
      chk("async_rst_alu", ex_mem_alu_result, 0);
      chk("async_rst_wreg", 32'(ex_mem_write_reg), 0);
      clr();
      tick();
      reset = 1'b1;
      repeat (2) tick();
      chk("idle_valid", 32'(ex_mem_valid), 0);

      // R-type sub to zero
      set_op(2'b10, 1'b0, 1'b1, 32'd5, 32'd5, 32'h22);
      rd = 5'd7; rt = 5'd3; ctl_wb = 2'b11;
      tick();
      chk("sub_alu", ex_mem_alu_result, 0);
      chk("sub_zero", 32'(ex_mem_zero), 1);
      chk("sub_wreg", 32'(ex_mem_write_reg), 7);
      chk("sub_valid", 32'(ex_mem_valid), 1);

      // beq, then a flushed instruction
      set_op(2'b01, 1'b0, 1'b0, 32'd9, 32'd9, 32'd4);
      npc = 32'h100; ctl_branch = 1'b1;
      tick();
      chk("beq_target", ex_mem_target, 32'h110);
      chk("beq_zero", 32'(ex_mem_zero), 1);
      chk("beq_branch", 32'(ex_mem_branch), 1);
      flush = 1'b1;
      tick();
      chk("flush_valid", 32'(ex_mem_valid), 0);
      chk("flush_branch", 32'(ex_mem_branch), 0);

      // store: address add, store data bypasses ALUSrc
      set_op(2'b00, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h10);
      ctl_memwrite = 1'b1;
      tick();
      chk("sw_alu", ex_mem_alu_result, 32'h20);
      chk("sw_wdata", ex_mem_write_data, 32'hDEADBEEF);
      chk("sw_memwrite", 32'(ex_mem_memwrite), 1);

      foreach (vecs[i]) begin
         set_op(vecs[i].op, 1'b0, 1'b0, vecs[i].a, vecs[i].b, vecs[i].im);
         rt = 5'(i);
         tick();
         chk($sformatf("vec%0d_alu", i), ex_mem_alu_result, vecs[i].res);
      end

      run_mult("mul7x6", 32'd7, 32'd6, 32'd42);
      run_mult("mulFx2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

      // MULT aborted by flush in its tenth busy cycle
      set_op(2'b10, 1'b0, 1'b1, 32'd5, 32'd5, 32'h18);
      rd = 5'd4;
      tick();
      repeat (9) tick();
      chk("abort_busy_before", 32'(busy), 1);
      flush = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(ex_mem_valid), 0);
      set_op(2'b00, 1'b0, 1'b1, 32'd3, 32'd4, 32'd0);
      rd = 5'd4;
      tick();
      chk("post_abort_add", ex_mem_alu_result, 7);
      chk("post_abort_valid", 32'(ex_mem_valid), 1);
      clr();
      cnt = 0;
      repeat (40) begin
         tick();
         if (ex_mem_valid) cnt++;
      end
      chk("abort_no_result", 32'(cnt), 0);

      // reset in the middle of a multiply
      set_op(2'b10, 1'b0, 1'b1, 32'd3, 32'd3, 32'h18);
      tick();
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("mulrst_busy", 32'(busy), 0);
      chk("mulrst_valid", 32'(ex_mem_valid), 0);
      clr();
      tick();
      reset = 1'b1;
      cnt = 0;
      repeat (40) begin
         tick();
         if (ex_mem_valid || busy) cnt++;
      end
      chk("mulrst_no_result", 32'(cnt), 0);

`ifdef EX_FORWARD_EN
      set_op(2'b00, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0);
      fwd_a_sel = 2'b10; mem_fwd_data = 32'h20;
      tick();
      chk("fwd_a_mem", ex_mem_alu_result, 32'h21);
      set_op(2'b00, 1'b1, 1'b0, 32'h10, 32'd0, 32'h4);
      fwd_b_sel = 2'b01; wb_fwd_data = 32'h100; ctl_memwrite = 1'b1;
      tick();
      chk("fwd_b_wdata", ex_mem_write_data, 32'h100);
      chk("fwd_b_alu", ex_mem_alu_result, 32'h14);
`endif

      clr();
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
